// File: rtl/pp_pipeline_accel_fifo_param.sv
// rtl/pp_pipeline_accel_fifo_param.sv - parametrised shift-register stream FIFO with optional output register
// Occupancy and all status flags are registered from the next-state count.
module pp_pipeline_accel_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 3,
  parameter int OUT_REG    = 0,
  parameter int AF_THRESH  = 2,
  parameter int AE_THRESH  = 1,
  localparam int CAP       = DEPTH + OUT_REG,
  localparam int CNT_W     = $clog2(CAP + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_clear,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CNT_W-1:0]      if_num_data_valid,
  output logic [CNT_W-1:0]      if_fifo_cap,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_overflow,
  output logic                  if_underflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  wr_req, rd_req, wr_acc, rd_acc;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [DATA_WIDTH-1:0] srl_d [DEPTH];

  always_comb begin
    wr_req = if_write & if_write_ce;
    rd_req = if_read & if_read_ce;
    // A flush cycle swallows both requests entirely.
    wr_acc = wr_req & full_n_q & ~if_clear;
    rd_acc = rd_req & empty_n_q & ~if_clear;

    cnt_d = cnt_q;
    if (if_clear) begin
      cnt_d = '0;
    end else if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    full_n_d  = (cnt_d != CNT_W'(CAP));
    empty_n_d = (cnt_d != '0);
    af_d      = (cnt_d >= CNT_W'(AF_THRESH));
    ae_d      = (cnt_d <= CNT_W'(AE_THRESH));

    ovf_d = if_clear ? 1'b0 : (ovf_q | (wr_req & ~full_n_q));
    unf_d = if_clear ? 1'b0 : (unf_q | (rd_req & ~empty_n_q));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      srl_d[i] = srl_q[i];
    end
    if (wr_acc) begin
      srl_d[0] = if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_d[i] = srl_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      srl_q[i] <= srl_d[i];
    end
  end

  if (OUT_REG == 0) begin : g_comb_out
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
      rd_idx = '0;
      if (cnt_q != '0) begin
        rd_idx = IDX_W'(cnt_q - CNT_W'(1));
      end
    end

    assign if_dout = srl_q[rd_idx];
  end else begin : g_reg_out
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [IDX_W-1:0]      tail_idx;
    logic                  srl_has;

    // The SRL holds count-1 entries behind the head register.
    always_comb begin
      srl_has  = (cnt_q >= CNT_W'(2));
      tail_idx = '0;
      if (srl_has) begin
        tail_idx = IDX_W'(cnt_q - CNT_W'(2));
      end
      dout_d = dout_q;
      if (!empty_n_q || rd_acc) begin
        if (srl_has) begin
          dout_d = srl_q[tail_idx];
        end else if (wr_acc) begin
          dout_d = if_din;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign if_dout = dout_q;
  end

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = cnt_q;
  assign if_fifo_cap       = CNT_W'(CAP);
  assign if_almost_full    = af_q;
  assign if_almost_empty   = ae_q;
  assign if_overflow       = ovf_q;
  assign if_underflow      = unf_q;

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_param.sv
// tb/tb_pp_pipeline_accel_fifo_param.sv - bench for both OUT_REG variants driven from shared stimulus
// Instance 0: DEPTH=3 OUT_REG=0 (CAP 3); instance 1: DEPTH=3 OUT_REG=1 (CAP 4).
module tb_pp_pipeline_accel_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        wr_ce = 1'b1;
  logic        rd_ce = 1'b1;
  logic [15:0] din = '0;

  logic        full_n0, empty_n0, af0, ae0, ovf0, unf0;
  logic [15:0] dout0;
  logic [1:0]  cnt0, cap0;
  logic        full_n1, empty_n1, af1, ae1, ovf1, unf1;
  logic [15:0] dout1;
  logic [2:0]  cnt1, cap1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pp_pipeline_accel_fifo_param #(.DATA_WIDTH(16), .DEPTH(3), .OUT_REG(0), .AF_THRESH(2), .AE_THRESH(1)) u0 (
    .clk(clk), .reset_n(rst_n), .if_clear(clr), .if_write_ce(wr_ce), .if_write(wr), .if_din(din),
    .if_full_n(full_n0), .if_read_ce(rd_ce), .if_read(rd), .if_dout(dout0), .if_empty_n(empty_n0),
    .if_num_data_valid(cnt0), .if_fifo_cap(cap0), .if_almost_full(af0), .if_almost_empty(ae0),
    .if_overflow(ovf0), .if_underflow(unf0)
  );

  pp_pipeline_accel_fifo_param #(.DATA_WIDTH(16), .DEPTH(3), .OUT_REG(1), .AF_THRESH(2), .AE_THRESH(1)) u1 (
    .clk(clk), .reset_n(rst_n), .if_clear(clr), .if_write_ce(wr_ce), .if_write(wr), .if_din(din),
    .if_full_n(full_n1), .if_read_ce(rd_ce), .if_read(rd), .if_dout(dout1), .if_empty_n(empty_n1),
    .if_num_data_valid(cnt1), .if_fifo_cap(cap1), .if_almost_full(af1), .if_almost_empty(ae1),
    .if_overflow(ovf1), .if_underflow(unf1)
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  // Behavioural model: a plain queue per instance plus sticky error bits.
  int          cap_m [2] = '{3, 4};
  logic [15:0] mq [2][$];
  logic        ovf_m [2] = '{1'b0, 1'b0};
  logic        unf_m [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        ovf_m[k] = 1'b0;
        unf_m[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int sz;
        sz = mq[k].size();
        if (clr) begin
          mq[k].delete();
          ovf_m[k] = 1'b0;
          unf_m[k] = 1'b0;
        end else begin
          if (wr && wr_ce && sz == cap_m[k]) ovf_m[k] = 1'b1;
          if (rd && rd_ce && sz == 0) unf_m[k] = 1'b1;
          if (rd && rd_ce && sz > 0) void'(mq[k].pop_front());
          if (wr && wr_ce && sz < cap_m[k]) mq[k].push_back(din);
        end
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = mq[0].size();
    chk("u0_count", int'(cnt0), sz);
    chk("u0_empty_n", int'(empty_n0), int'(sz != 0));
    chk("u0_full_n", int'(full_n0), int'(sz != 3));
    chk("u0_af", int'(af0), int'(sz >= 2));
    chk("u0_ae", int'(ae0), int'(sz <= 1));
    chk("u0_ovf", int'(ovf0), int'(ovf_m[0]));
    chk("u0_unf", int'(unf0), int'(unf_m[0]));
    if (sz > 0) chk("u0_dout", int'(dout0), int'(mq[0][0]));
    sz = mq[1].size();
    chk("u1_count", int'(cnt1), sz);
    chk("u1_empty_n", int'(empty_n1), int'(sz != 0));
    chk("u1_full_n", int'(full_n1), int'(sz != 4));
    chk("u1_af", int'(af1), int'(sz >= 2));
    chk("u1_ae", int'(ae1), int'(sz <= 1));
    chk("u1_ovf", int'(ovf1), int'(ovf_m[1]));
    chk("u1_unf", int'(unf1), int'(unf_m[1]));
    if (sz > 0) chk("u1_dout", int'(dout1), int'(mq[1][0]));
  end

  task automatic step(input logic w, input logic r, input logic c, input logic [15:0] d);
    wr = w; rd = r; clr = c; din = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_u0_empty_n", int'(empty_n0), 0);
    chk("rst_u0_full_n", int'(full_n0), 1);
    chk("rst_u0_count", int'(cnt0), 0);
    chk("rst_u0_ae", int'(ae0), 1);
    chk("rst_u0_cap", int'(cap0), 3);
    chk("rst_u1_cap", int'(cap1), 4);

    step(1, 0, 0, 16'h0011);
    step(1, 0, 0, 16'h0022);
    step(1, 0, 0, 16'h0033);
    chk("fill_u0_full_n", int'(full_n0), 0);
    chk("fill_u1_count", int'(cnt1), 3);
    step(1, 0, 0, 16'h0044);
    step(1, 0, 0, 16'h0055);
    chk("ovf_u0", int'(ovf0), 1);
    chk("ovf_u1", int'(ovf1), 1);
    chk("ovf_u1_full_n", int'(full_n1), 0);
    chk("ovf_u1_count", int'(cnt1), 4);

    chk("rd0_u0_dout", int'(dout0), 'h11);
    chk("rd0_u1_dout", int'(dout1), 'h11);
    step(0, 1, 0, 16'h0);
    chk("rd1_u0_dout", int'(dout0), 'h22);
    chk("rd1_u1_dout", int'(dout1), 'h22);
    step(0, 1, 0, 16'h0);
    chk("rd2_u0_dout", int'(dout0), 'h33);
    chk("rd2_u1_dout", int'(dout1), 'h33);
    step(0, 1, 0, 16'h0);
    chk("rd3_u0_empty_n", int'(empty_n0), 0);
    chk("rd3_u1_dout", int'(dout1), 'h44);
    step(0, 1, 0, 16'h0);
    chk("rd4_u1_empty_n", int'(empty_n1), 0);
    chk("rd4_u0_unf", int'(unf0), 1);

    step(0, 0, 1, 16'h0);
    chk("clr_u0_ovf", int'(ovf0), 0);
    chk("clr_u1_unf", int'(unf1), 0);

    step(1, 0, 0, 16'd1000);
    for (int i = 1; i <= 100; i++) step(1, 1, 0, 16'(1000 + i));
    chk("stream_u0_count", int'(cnt0), 1);
    chk("stream_u1_count", int'(cnt1), 1);
    chk("stream_u0_dout", int'(dout0), 1100);
    chk("stream_u1_dout", int'(dout1), 1100);
    chk("stream_u1_errs", int'({ovf1, unf1, ovf0, unf0}), 0);
    step(0, 1, 0, 16'h0);

    for (int c = 1; c <= 3; c++) begin
      step(1, 0, 0, 16'(c));
      chk("up_u0_af", int'(af0), int'(c >= 2));
      chk("up_u0_ae", int'(ae0), int'(c <= 1));
    end
    for (int c = 2; c >= 0; c--) begin
      step(0, 1, 0, 16'h0);
      chk("dn_u0_af", int'(af0), int'(c >= 2));
      chk("dn_u0_ae", int'(ae0), int'(c <= 1));
    end

    step(1, 0, 0, 16'h00a1);
    step(1, 0, 0, 16'h00a2);
    step(1, 0, 1, 16'h00a3);
    chk("flush_u0_count", int'(cnt0), 0);
    chk("flush_u0_empty_n", int'(empty_n0), 0);
    chk("flush_u1_count", int'(cnt1), 0);
    step(0, 1, 0, 16'h0);
    chk("empty_rd_u0_unf", int'(unf0), 1);
    chk("empty_rd_u1_unf", int'(unf1), 1);

    step(1, 0, 0, 16'h00b1);
    step(1, 0, 0, 16'h00b2);
    wr = 1'b1; din = 16'h00b3;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_u0_count", int'(cnt0), 0);
    chk("arst_u0_empty_n", int'(empty_n0), 0);
    chk("arst_u0_full_n", int'(full_n0), 1);
    chk("arst_u0_af", int'(af0), 0);
    chk("arst_u0_ae", int'(ae0), 1);
    chk("arst_u1_unf", int'(unf1), 0);
    chk("arst_u1_dout", int'(dout1), 0);
    wr = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pp_pipeline_accel_fifo_param.md
# pp_pipeline_accel_fifo_param

Parametrised shift-register stream FIFO for the pp_pipeline_accel dataflow channels. It is the successor to the fixed-size HLS channel FIFOs. It adds:
- arbitrary `DATA_WIDTH`/`DEPTH`;
- an optional registered output stage;
- programmable almost-full/almost-empty flags;
- a synchronous flush;
- sticky overflow/underflow error flags.

It sits between producer and consumer processes and keeps the existing `if_*` handshake, so existing stages connect unchanged.

## Interface
- `DATA_WIDTH`, 16: payload width in bits.
- `DEPTH`, 3: shift-register entries, ≥2.
- `OUT_REG`, 0: 1 adds a registered output stage. Total capacity `CAP` = `DEPTH` + `OUT_REG`.
- `AF_THRESH`, 2: `if_almost_full` asserted when count ≥ `AF_THRESH`. Range 1..`CAP`.
- `AE_THRESH`, 1: `if_almost_empty` asserted when count ≤ `AE_THRESH`. Range 0..`CAP`-1.
- Derived localparam `CNT_W` = $clog2(`CAP`+1).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous assert, active-low. Release is synchronous to `clk` externally.
- `if_clear` in 1: synchronous flush, highest priority.
- `if_write_ce`, `if_write` in 1 each: write request. Request `wr_req` = `if_write` & `if_write_ce`.
- `if_din` in `DATA_WIDTH`: write data.
- `if_full_n` out 1: space available.
- `if_read_ce`, `if_read` in 1 each: read request. Request `rd_req` = `if_read` & `if_read_ce`.
- `if_dout` out `DATA_WIDTH`: head-of-queue data, valid while `if_empty_n`=1.
- `if_empty_n` out 1: data available.
- `if_num_data_valid` out `CNT_W`: current occupancy.
- `if_fifo_cap` out `CNT_W`: constant `CAP`.
- `if_almost_full`, `if_almost_empty` out 1: threshold flags.
- `if_overflow`, `if_underflow` out 1: sticky error flags.

## Operation
- Accepted write `wr_acc` = `wr_req` & `if_full_n`. Accepted read `rd_acc` = `rd_req` & `if_empty_n`.
- Count update:
  - `wr_acc` without `rd_acc`: +1.
  - `rd_acc` without `wr_acc`: −1.
  - Both or neither: unchanged.
- `if_full_n`, `if_empty_n`, almost flags and count are all registered. Each is derived from the next count:
  - `if_full_n` = next≠`CAP`.
  - `if_empty_n` = next≠0.
  - `if_almost_full` = next≥`AF_THRESH`.
  - `if_almost_empty` = next≤`AE_THRESH`.
- Storage: an SRL array shifts on `wr_acc` (new data into entry 0). Data entries have no reset.
- `OUT_REG`=0:
  - `if_dout` = SRL[count−1], combinational read index.
  - Index 0 is used when count=0.
- `OUT_REG`=1: the output register `dout_q` holds the head; the SRL holds count−1 entries behind it.
  - `dout_q` loads when (`if_empty_n`=0 or `rd_acc`) and a next item exists.
  - The next item is taken from the SRL tail if the SRL is non-empty, else directly from `if_din` when `wr_acc` (bypass).
  - `if_dout` = `dout_q`.
- Overflow: `wr_req` while `if_full_n`=0 sets `if_overflow`; the data is dropped.
- Underflow: `rd_req` while `if_empty_n`=0 sets `if_underflow`.
- Both error flags hold until reset or `if_clear`.
- `if_clear`=1:
  - Next cycle: count=0, `if_empty_n`=0, `if_full_n`=1, `if_almost_empty`=1, `if_almost_full`=0, both error flags cleared.
  - Same-cycle `wr_req`/`rd_req` are ignored: no data stored, no error flags set.
- Full with `wr_req`+`rd_req`: read accepted, write refused (`if_full_n`=0 gates it). The count becomes `CAP`−1 and `if_overflow` is set.
- Empty with both requests: write accepted, read refused, `if_underflow` set.

## Timing
- Reset (`reset_n`=0), asynchronous:
  - count=0, `if_empty_n`=0, `if_full_n`=1.
  - `if_almost_empty`=1; `if_almost_full`=0.
  - `if_overflow`=`if_underflow`=0.
  - `dout_q`=0.
- Mid-operation reset discards all contents immediately. Outputs take their reset values without waiting for a clock edge.
- Write-to-read latency: a write accepted at edge N gives `if_empty_n`=1 after edge N, so the data is readable in cycle N+1. This holds for both `OUT_REG` values.
- `if_full_n` deasserts in the cycle after the write that fills to `CAP`. It reasserts in the cycle after the first read from full.
- Reads sustain 1 item/cycle. Simultaneous accepted read+write at any non-boundary count sustains full throughput with the count unchanged.
- `OUT_REG`=1: `if_dout` is driven only from a flop, with no combinational path from `if_read` to `if_dout`.

## Test plan
- Reset then idle, `DEPTH`=3, `OUT_REG`=0 → `if_empty_n`=0, `if_full_n`=1, `if_num_data_valid`=0, `if_almost_empty`=1, `if_fifo_cap`=3.
- Write 0x0011, 0x0022, 0x0033 on consecutive cycles, no reads → `if_full_n`=0 after the third edge. Then read ×3 → `if_dout` gives 0x0011, 0x0022, 0x0033 in order, then `if_empty_n`=0.
- `OUT_REG`=1, `DEPTH`=3: write 4 words then hold a 5th write → `if_fifo_cap`=4, the 5th is refused, `if_overflow`=1. Drain → all 4 words in order.
- Continuous write+read each cycle for 100 cycles starting at count=1, with an incrementing pattern → count stays 1, no data loss or duplication, no error flags.
- `AF_THRESH`=2, `AE_THRESH`=1: fill 0→3 then drain to 0 → `if_almost_full` rises at count 2 and falls at count 1; `if_almost_empty`=1 at counts 0..1.
- Fill to 2, pulse `if_clear` together with `if_write` → next cycle count=0 and `if_empty_n`=0. Read while empty → `if_underflow`=1.
- Assert `reset_n`=0 mid-write → flags return to reset values immediately.
